// File: rtl/fft_bfp_block_align_pkg.sv
// Shared widths, reader state type and arithmetic helpers for the
// block-floating-point alignment block.
package fft_bfp_block_align_pkg;

    localparam int MAN_W   = 16;
    localparam int EXP_W   = 5;
    localparam int LDN_MAX = 11;
    localparam int RAM_AW  = LDN_MAX + 1;
    localparam int RAM_DW  = 2 * MAN_W + EXP_W;
    localparam int SH_W    = $clog2(MAN_W);

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_e;

    // Index of the last sample of a block; unsupported lengths fall back to the largest block.
    function automatic logic [LDN_MAX-1:0] last_index(input logic [3:0] ldn);
        logic [3:0] l;
        l = (ldn >= 4'd4 && ldn <= 4'(LDN_MAX)) ? ldn : 4'(LDN_MAX);
        return {LDN_MAX{1'b1}} >> (4'(LDN_MAX) - l);
    endfunction

    // Arithmetic right shift with round-half-away-from-zero; shifts of MAN_W or more flush to zero.
    function automatic logic signed [MAN_W-1:0] align_mant(input logic signed [MAN_W-1:0] x,
                                                           input logic [EXP_W:0] sh);
        logic signed [MAN_W:0] one;
        logic signed [MAN_W:0] ext;
        logic signed [MAN_W:0] half;
        logic signed [MAN_W:0] sum;
        logic signed [MAN_W:0] shifted;
        logic [SH_W-1:0]       s;
        one = 1;
        if (sh == '0) begin
            return x;
        end
        if (sh >= (EXP_W+1)'(MAN_W)) begin
            return '0;
        end
        s       = sh[SH_W-1:0];
        ext     = {x[MAN_W-1], x};
        half    = one <<< (s - SH_W'(1));
        sum     = x[MAN_W-1] ? (ext + half - one) : (ext + half);
        shifted = sum >>> s;
        return shifted[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fft_bfp_block_align_if.sv
// Per-sample block-floating-point stream: block start, valid, mantissa pair and exponent.
interface fft_bfp_block_align_if;
    import fft_bfp_block_align_pkg::*;

    logic                    block_sync;
    logic                    data_val;
    logic signed [MAN_W-1:0] data_real;
    logic signed [MAN_W-1:0] data_imag;
    logic signed [EXP_W-1:0] data_exp;

    modport master (output block_sync, data_val, data_real, data_imag, data_exp);
    modport slave  (input  block_sync, data_val, data_real, data_imag, data_exp);

endinterface

// File: rtl/fft_bfp_block_align_dpram.sv
// Simple dual-port RAM, one write port and one synchronous read port.
module fft_bfp_block_align_dpram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 37
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/fft_bfp_block_align.sv
// Buffers one FFT block in a ping-pong RAM, tracks the block's maximum exponent,
// then replays the block with every mantissa aligned to that common exponent.
module fft_bfp_block_align
    import fft_bfp_block_align_pkg::*;
(
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic [3:0]            ldn_rg_i,
    fft_bfp_block_align_if.slave  in_if,
    fft_bfp_block_align_if.master out_if,
    output logic                  ovf_o
);

    logic                          wrActive_q, wrActive_d;
    logic                          wrStore_q, wrStore_d;
    logic                          wrBank_q, wrBank_d;
    logic [LDN_MAX-1:0]            wrCnt_q, wrCnt_d;
    logic [LDN_MAX-1:0]            wrLast_q, wrLast_d;
    logic signed [EXP_W-1:0]       expMax_q, expMax_d;
    logic                          setPend;
    logic                          ovf_q, ovf_d;

    logic [1:0]                    pend_q;
    logic [1:0][LDN_MAX-1:0]       pendLast_q;
    logic [1:0][EXP_W-1:0]         pendExp_q;
    logic                          olderBank_q;
    logic [1:0]                    clrPend;

    rd_state_e                     rdState_q, rdState_d;
    logic                          rdBank_q, rdBank_d;
    logic [LDN_MAX-1:0]            rdCnt_q, rdCnt_d;
    logic                          rdCurBank;
    logic                          rdFirst;

    logic                          ramWe;
    logic                          ramRdEn;
    logic [RAM_AW-1:0]             ramWrAddr;
    logic [RAM_AW-1:0]             ramRdAddr;
    logic [RAM_DW-1:0]             ramRdData;

    logic                          s1Val_q, s1First_q;
    logic signed [EXP_W-1:0]       s1Exp_q;

    logic signed [MAN_W-1:0]       ramReal, ramImag;
    logic signed [EXP_W-1:0]       ramExp;
    logic [EXP_W:0]                shAmt;
    logic signed [MAN_W-1:0]       alignReal, alignImag;

    logic                          outVal_q, outSync_q;
    logic signed [MAN_W-1:0]       outReal_q, outImag_q;
    logic signed [EXP_W-1:0]       outExp_q;

    // Writer: opens a block on sync, picks a free bank (or drops), tracks count and max exponent.
    always_comb begin
        wrActive_d = wrActive_q;
        wrStore_d  = wrStore_q;
        wrBank_d   = wrBank_q;
        wrCnt_d    = wrCnt_q;
        wrLast_d   = wrLast_q;
        expMax_d   = expMax_q;
        ramWe      = 1'b0;
        ramWrAddr  = {wrBank_q, wrCnt_q};
        setPend    = 1'b0;
        ovf_d      = 1'b0;
        if (in_if.data_val) begin
            if (in_if.block_sync) begin
                wrActive_d = 1'b1;
                wrCnt_d    = LDN_MAX'(1);
                wrLast_d   = last_index(ldn_rg_i);
                expMax_d   = in_if.data_exp;
                if (!pend_q[0]) begin
                    wrStore_d = 1'b1;
                    wrBank_d  = 1'b0;
                end else if (!pend_q[1]) begin
                    wrStore_d = 1'b1;
                    wrBank_d  = 1'b1;
                end else begin
                    wrStore_d = 1'b0;
                end
                ramWe     = wrStore_d;
                ramWrAddr = {wrBank_d, LDN_MAX'(0)};
            end else if (wrActive_q) begin
                ramWe    = wrStore_q;
                wrCnt_d  = wrCnt_q + LDN_MAX'(1);
                expMax_d = (in_if.data_exp > expMax_q) ? in_if.data_exp : expMax_q;
                if (wrCnt_q == wrLast_q) begin
                    wrActive_d = 1'b0;
                    setPend    = wrStore_q;
                    ovf_d      = !wrStore_q;
                end
            end
        end
    end

    // Writer registers, bank pending flags and the age of the pending banks.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wrActive_q  <= 1'b0;
            wrStore_q   <= 1'b0;
            wrBank_q    <= 1'b0;
            wrCnt_q     <= '0;
            wrLast_q    <= '0;
            expMax_q    <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= '0;
            pendLast_q  <= '0;
            pendExp_q   <= '0;
            olderBank_q <= 1'b0;
        end else begin
            wrActive_q <= wrActive_d;
            wrStore_q  <= wrStore_d;
            wrBank_q   <= wrBank_d;
            wrCnt_q    <= wrCnt_d;
            wrLast_q   <= wrLast_d;
            expMax_q   <= expMax_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_q & ~clrPend;
            if (setPend) begin
                pend_q[wrBank_q]     <= 1'b1;
                pendLast_q[wrBank_q] <= wrLast_q;
                pendExp_q[wrBank_q]  <= expMax_d;
                olderBank_q          <= (pend_q[~wrBank_q] && !clrPend[~wrBank_q]) ? ~wrBank_q : wrBank_q;
            end
        end
    end

    // Reader FSM: the first read is issued from idle so a block starts with no wasted cycle.
    always_comb begin
        rdState_d = rdState_q;
        rdBank_d  = rdBank_q;
        rdCnt_d   = rdCnt_q;
        rdCurBank = rdBank_q;
        rdFirst   = 1'b0;
        ramRdEn   = 1'b0;
        ramRdAddr = {rdBank_q, rdCnt_q};
        clrPend   = '0;
        case (rdState_q)
            RD_IDLE: begin
                if (|pend_q) begin
                    rdCurBank = pend_q[olderBank_q] ? olderBank_q : ~olderBank_q;
                    rdFirst   = 1'b1;
                    ramRdEn   = 1'b1;
                    ramRdAddr = {rdCurBank, LDN_MAX'(0)};
                    rdBank_d  = rdCurBank;
                    rdCnt_d   = LDN_MAX'(1);
                    rdState_d = RD_READ;
                end
            end
            RD_READ: begin
                ramRdEn = 1'b1;
                rdFirst = (rdCnt_q == '0);
                if (rdCnt_q == pendLast_q[rdBank_q]) begin
                    clrPend[rdBank_q] = 1'b1;
                    if (pend_q[~rdBank_q]) begin
                        rdBank_d = ~rdBank_q;
                        rdCnt_d  = '0;
                    end else begin
                        rdState_d = RD_IDLE;
                    end
                end else begin
                    rdCnt_d = rdCnt_q + LDN_MAX'(1);
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    // Reader state register and the pipeline stage aligned with the RAM output.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rdState_q <= RD_IDLE;
            rdBank_q  <= 1'b0;
            rdCnt_q   <= '0;
            s1Val_q   <= 1'b0;
            s1First_q <= 1'b0;
            s1Exp_q   <= '0;
        end else begin
            rdState_q <= rdState_d;
            rdBank_q  <= rdBank_d;
            rdCnt_q   <= rdCnt_d;
            s1Val_q   <= ramRdEn;
            s1First_q <= rdFirst;
            s1Exp_q   <= pendExp_q[rdCurBank];
        end
    end

    fft_bfp_block_align_dpram #(
        .ADDR_W (RAM_AW),
        .DATA_W (RAM_DW)
    ) u_ram (
        .clk_i     (clk_sys),
        .wr_en_i   (ramWe),
        .wr_addr_i (ramWrAddr),
        .wr_data_i ({in_if.data_real, in_if.data_imag, in_if.data_exp}),
        .rd_en_i   (ramRdEn),
        .rd_addr_i (ramRdAddr),
        .rd_data_o (ramRdData)
    );

    // Shift distance is never negative because the block exponent is the maximum.
    always_comb begin
        ramReal   = ramRdData[RAM_DW-1 -: MAN_W];
        ramImag   = ramRdData[EXP_W +: MAN_W];
        ramExp    = ramRdData[EXP_W-1:0];
        shAmt     = {s1Exp_q[EXP_W-1], s1Exp_q} - {ramExp[EXP_W-1], ramExp};
        alignReal = align_mant(ramReal, shAmt);
        alignImag = align_mant(ramImag, shAmt);
    end

    // Registered outputs, forced to zero whenever no sample is presented.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            outVal_q  <= 1'b0;
            outSync_q <= 1'b0;
            outReal_q <= '0;
            outImag_q <= '0;
            outExp_q  <= '0;
        end else if (s1Val_q) begin
            outVal_q  <= 1'b1;
            outSync_q <= s1First_q;
            outReal_q <= alignReal;
            outImag_q <= alignImag;
            outExp_q  <= s1Exp_q;
        end else begin
            outVal_q  <= 1'b0;
            outSync_q <= 1'b0;
            outReal_q <= '0;
            outImag_q <= '0;
            outExp_q  <= '0;
        end
    end

    assign out_if.data_val   = outVal_q;
    assign out_if.block_sync = outSync_q;
    assign out_if.data_real  = outReal_q;
    assign out_if.data_imag  = outImag_q;
    assign out_if.data_exp   = outExp_q;
    assign ovf_o             = ovf_q;

endmodule

// File: tb/tb_fft_bfp_block_align.sv
// Directed scoreboard bench for the block-floating-point alignment block.
module tb_fft_bfp_block_align;
    import fft_bfp_block_align_pkg::*;

    typedef struct packed {
        logic        first;
        logic [15:0] re;
        logic [15:0] im;
        logic [4:0]  ex;
    } sb_item_t;

    logic       clk_sys   = 1'b0;
    logic       rst_sys_n = 1'b1;
    logic [3:0] ldn_rg    = 4'd4;
    logic       ovf;

    fft_bfp_block_align_if inIf ();
    fft_bfp_block_align_if outIf ();

    fft_bfp_block_align dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .ldn_rg_i  (ldn_rg),
        .in_if     (inIf),
        .out_if    (outIf),
        .ovf_o     (ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int       assertCnt = 0;
    int       failCnt   = 0;
    int       cycleCnt  = 0;
    int       ovfCnt    = 0;
    int       lastValidCycle = 0;
    int       lastInCycle    = 0;
    sb_item_t sbQ[$];
    int       syncCycles[$];
    int       blkRe  [2048];
    int       blkIm  [2048];
    int       blkExp [2048];

    // Free-running cycle counter used for latency and contiguity checks.
    always @(posedge clk_sys) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCnt++;
        assert (obs === expv) else begin
            failCnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Independent reference: round half away from zero on the magnitude.
    function automatic int modelAlign(input int x, input int sh);
        int mag;
        int r;
        if (sh == 0) return x;
        if (sh >= 16) return 0;
        mag = (x < 0) ? -x : x;
        r   = (mag + (1 << (sh - 1))) >> sh;
        return (x < 0) ? -r : r;
    endfunction

    // Output monitor: pops the scoreboard on every valid sample, checks idle zeros otherwise.
    always @(negedge clk_sys) begin
        sb_item_t item;
        if (ovf === 1'b1) ovfCnt++;
        if (outIf.data_val === 1'b1) begin
            lastValidCycle = cycleCnt;
            if (outIf.block_sync === 1'b1) syncCycles.push_back(cycleCnt);
            checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
                item = sbQ.pop_front();
                checkOutput("block_sync", {31'd0, outIf.block_sync}, {31'd0, item.first});
                checkOutput("data_real",  {16'd0, outIf.data_real},  {16'd0, item.re});
                checkOutput("data_imag",  {16'd0, outIf.data_imag},  {16'd0, item.im});
                checkOutput("block_exp",  {27'd0, outIf.data_exp},   {27'd0, item.ex});
            end
        end else begin
            checkOutput("idle_zero", {28'd0, outIf.block_sync === 1'b1, |outIf.data_real,
                                      |outIf.data_imag, |outIf.data_exp}, 32'd0);
        end
    end

    task automatic applyStimulus(input bit sync, input bit val, input int re, input int im, input int ex);
        @(posedge clk_sys);
        #1;
        inIf.block_sync = sync;
        inIf.data_val   = val;
        inIf.data_real  = 16'(re);
        inIf.data_imag  = 16'(im);
        inIf.data_exp   = 5'(ex);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    endtask

    // Drives one block from the blk* arrays; stored blocks push their expected output.
    task automatic sendBlock(input int n, input int ldnV, input bit store);
        int       maxE;
        sb_item_t it;
        ldn_rg = 4'(ldnV);
        for (int i = 0; i < n; i++) applyStimulus(i == 0, 1'b1, blkRe[i], blkIm[i], blkExp[i]);
        lastInCycle = cycleCnt + 1;
        if (store) begin
            maxE = blkExp[0];
            for (int i = 1; i < n; i++) if (blkExp[i] > maxE) maxE = blkExp[i];
            for (int i = 0; i < n; i++) begin
                it.first = (i == 0);
                it.re    = 16'(modelAlign(blkRe[i], maxE - blkExp[i]));
                it.im    = 16'(modelAlign(blkIm[i], maxE - blkExp[i]));
                it.ex    = 5'(maxE);
                sbQ.push_back(it);
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int c = 0;
        while (sbQ.size() != 0 && c < budget) begin
            @(posedge clk_sys);
            c++;
        end
        checkOutput("drain", 32'(sbQ.size()), 32'd0);
        idleCycles(8);
    endtask

    task automatic fillRandom(input int n);
        for (int i = 0; i < n; i++) begin
            blkRe[i]  = int'($signed(16'($urandom)));
            blkIm[i]  = int'($signed(16'($urandom)));
            blkExp[i] = int'($urandom_range(31)) - 16;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        inIf.block_sync = 1'b0;
        inIf.data_val   = 1'b0;
        inIf.data_real  = '0;
        inIf.data_imag  = '0;
        inIf.data_exp   = '0;

        // Reset state
        #1 rst_sys_n = 1'b0;
        #1;
        checkOutput("rst_val",  {31'd0, outIf.data_val},   32'd0);
        checkOutput("rst_sync", {31'd0, outIf.block_sync}, 32'd0);
        checkOutput("rst_real", {16'd0, outIf.data_real},  32'd0);
        checkOutput("rst_imag", {16'd0, outIf.data_imag},  32'd0);
        checkOutput("rst_exp",  {27'd0, outIf.data_exp},   32'd0);
        checkOutput("rst_ovf",  {31'd0, ovf},              32'd0);
        repeat (3) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        idleCycles(4);

        // Test 1: constant exponent, pass-through, latency
        $display("[TB] test 1: N=16 uniform exponent");
        for (int k = 0; k < 16; k++) begin
            blkRe[k] = k; blkIm[k] = -k; blkExp[k] = 2;
        end
        syncCycles.delete();
        sendBlock(16, 4, 1'b1);
        idleCycles(1);
        waitDrain(100);
        checkOutput("t1_sync_count", 32'(syncCycles.size()), 32'd1);
        if (syncCycles.size() != 0) checkOutput("t1_latency", 32'(syncCycles[0] - lastInCycle), 32'd2);

        // Test 2: rounding by two
        $display("[TB] test 2: shift by 2 with rounding");
        blkRe[0] = 1000; blkIm[0] = -1000; blkExp[0] = 3;
        for (int k = 1; k < 16; k++) begin
            blkRe[k] = 7; blkIm[k] = -7; blkExp[k] = 1;
        end
        sendBlock(16, 4, 1'b1);
        idleCycles(1);
        waitDrain(100);

        // Test 3: shift beyond mantissa width
        $display("[TB] test 3: large shift flushes to zero");
        blkRe[0] = 500; blkIm[0] = -500; blkExp[0] = 15;
        for (int k = 1; k < 16; k++) begin
            blkRe[k] = 12345; blkIm[k] = -12345; blkExp[k] = -6;
        end
        sendBlock(16, 4, 1'b1);
        idleCycles(1);
        waitDrain(100);

        // Test 4: early sync discards the partial block
        $display("[TB] test 4: early block_sync");
        ovfCnt = 0;
        ldn_rg = 4'd4;
        for (int k = 0; k < 5; k++) applyStimulus(k == 0, 1'b1, 999, -999, 9);
        fillRandom(16);
        sendBlock(16, 4, 1'b1);
        idleCycles(1);
        waitDrain(100);
        checkOutput("t4_ovf", 32'(ovfCnt), 32'd0);

        // Test 5: three contiguous 2048-point blocks
        $display("[TB] test 5: back-to-back 2048 blocks");
        ovfCnt = 0;
        syncCycles.delete();
        for (int b = 0; b < 3; b++) begin
            fillRandom(2048);
            sendBlock(2048, 11, 1'b1);
        end
        idleCycles(1);
        waitDrain(3000);
        checkOutput("t5_ovf", 32'(ovfCnt), 32'd0);
        checkOutput("t5_sync_count", 32'(syncCycles.size()), 32'd3);
        if (syncCycles.size() == 3) begin
            checkOutput("t5_gap01", 32'(syncCycles[1] - syncCycles[0]), 32'd2048);
            checkOutput("t5_gap12", 32'(syncCycles[2] - syncCycles[1]), 32'd2048);
            checkOutput("t5_tail",  32'(lastValidCycle - syncCycles[2]), 32'd2047);
        end

        // Test 6a: long block followed by two short ones, second short one dropped
        $display("[TB] test 6: overflow and reset mid-read");
        ovfCnt = 0;
        fillRandom(2048);
        sendBlock(2048, 11, 1'b1);
        fillRandom(16);
        sendBlock(16, 4, 1'b1);
        fillRandom(16);
        sendBlock(16, 4, 1'b0);
        idleCycles(1);
        waitDrain(3000);
        checkOutput("t6_ovf", 32'(ovfCnt), 32'd1);

        // Test 6b: reset while replaying a block clears outputs immediately
        fillRandom(2048);
        sendBlock(2048, 11, 1'b1);
        idleCycles(100);
        #2 rst_sys_n = 1'b0;
        #1;
        checkOutput("t6_rst_val",  {31'd0, outIf.data_val},   32'd0);
        checkOutput("t6_rst_sync", {31'd0, outIf.block_sync}, 32'd0);
        checkOutput("t6_rst_real", {16'd0, outIf.data_real},  32'd0);
        checkOutput("t6_rst_exp",  {27'd0, outIf.data_exp},   32'd0);
        sbQ.delete();
        repeat (2) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        idleCycles(20);
        fillRandom(16);
        sendBlock(16, 4, 1'b1);
        idleCycles(1);
        waitDrain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
